// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative IEEE-754 single-precision divider.
// One quotient bit per DIV cycle (restoring division of 24-bit significands),
// then a single normalize/round cycle. Denormal inputs flush to zero and
// underflowing results flush to zero; no denormals are ever produced.
// ITER must be at least 26 (1 integer bit, 23 fraction bits, guard, round).
module fdiv_iter #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] y,
  output logic        valid_out
);

  localparam int          CW       = $clog2(ITER + 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  // Quotient bits below the 26 used for mantissa/guard only feed the sticky bit.
  localparam logic [ITER-1:0] LOW_MASK = ITER'((64'd1 << (ITER - 26)) - 64'd1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_e;

  // Operand class decided at accept time; the divide loop runs regardless so
  // the latency is identical for every class.
  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_NAN,
    CLS_ZERO,
    CLS_INF
  } cls_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     iter_q;
  logic              sign_q;
  cls_e              cls_q;
  logic signed [9:0] exp_q;
  logic [24:0]       rem_q;
  logic [23:0]       dvs_q;
  logic [ITER-1:0]   quo_q;
  logic [31:0]       y_q;

  // ---------------------------------------------------------------------------
  // Operand unpacking (evaluated on the accepting edge only)
  // ---------------------------------------------------------------------------
  logic [7:0]        ea, eb;
  logic              hid_a, hid_b;
  logic signed [9:0] exp_in;
  cls_e              cls_in;

  assign ea     = x1[30:23];
  assign eb     = x2[30:23];
  assign hid_a  = (ea != 8'd0);
  assign hid_b  = (eb != 8'd0);
  assign exp_in = signed'({2'b00, ea}) - signed'({2'b00, eb}) + 10'sd127;

  // Classify operands: NaN/inf inputs dominate, then zero dividend, then zero divisor.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    cls_in = CLS_NORMAL;
    if (ea == 8'hFF || eb == 8'hFF) begin
      cls_in = CLS_NAN;
    end else if (ea == 8'd0) begin
      cls_in = CLS_ZERO;
    end else if (eb == 8'd0) begin
      cls_in = CLS_INF;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------------
  logic        q_bit;
  logic [23:0] rem_sub;

  // Trial subtract: keep the difference when the divisor fits.
  always_comb begin
    q_bit   = (rem_q >= {1'b0, dvs_q});
    rem_sub = q_bit ? 24'(rem_q - {1'b0, dvs_q}) : 24'(rem_q);
  end

  // ---------------------------------------------------------------------------
  // Normalize, round to nearest even, pack
  // ---------------------------------------------------------------------------
  logic [25:0]       q_top;
  logic              low_sticky;
  logic              rem_nz;
  logic [22:0]       frac_raw;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       frac_rnd;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;
  logic [31:0]       y_calc;

  assign q_top      = quo_q[ITER-1 -: 26];
  assign low_sticky = |(quo_q & LOW_MASK);
  assign rem_nz     = |rem_q;

  // Left-normalize by one bit when the integer quotient bit is clear, then round.
  always_comb begin
    frac_raw = q_top[24:2];
    guard    = q_top[1];
    sticky   = q_top[0] | low_sticky | rem_nz;
    exp_norm = exp_q;
    if (!q_top[25]) begin
      frac_raw = q_top[23:1];
      guard    = q_top[0];
      sticky   = low_sticky | rem_nz;
      exp_norm = exp_q - 10'sd1;
    end
    round_up = guard & (sticky | frac_raw[0]);
    frac_rnd = {1'b0, frac_raw} + 24'(round_up);
    // A carry out of the fraction means the mantissa rolled over to 1.0.
    exp_fin  = exp_norm + (frac_rnd[23] ? 10'sd1 : 10'sd0);
  end

  // Select the packed result from the operand class and the final exponent.
  always_comb begin
    y_calc = {sign_q, exp_fin[7:0], frac_rnd[22:0]};
    case (cls_q)
      CLS_NAN:  y_calc = QNAN;
      CLS_ZERO: y_calc = {sign_q, 31'd0};
      CLS_INF:  y_calc = {sign_q, 8'hFF, 23'd0};
      default: begin
        if (exp_fin >= 10'sd255) begin
          y_calc = {sign_q, 8'hFF, 23'd0};
        end else if (exp_fin <= 10'sd0) begin
          y_calc = {sign_q, 31'd0};
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, ITER divide cycles, one normalize cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_in) state_d = DIV;
      DIV:  if (iter_q == CW'(ITER - 1)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Capture operands on accept, iterate in DIV, publish the result in NORM.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
      sign_q <= 1'b0;
      cls_q  <= CLS_NORMAL;
      exp_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      y_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            iter_q <= '0;
            sign_q <= x1[31] ^ x2[31];
            cls_q  <= cls_in;
            exp_q  <= exp_in;
            rem_q  <= {1'b0, hid_a, x1[22:0]};
            dvs_q  <= {hid_b, x2[22:0]};
            quo_q  <= '0;
          end
        end
        DIV: begin
          rem_q  <= {rem_sub, 1'b0};
          quo_q  <= {quo_q[ITER-2:0], q_bit};
          iter_q <= iter_q + CW'(1);
        end
        NORM: y_q <= y_calc;
        default: ;
      endcase
    end
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = (state_q == DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: scoreboard bench for fdiv_iter. The driver pushes the expected
// quotient and accept cycle for each request; a negedge monitor pops and
// compares whenever valid_out is seen.
module tb_fdiv_iter;

  localparam int LAT   = 28;
  localparam int N_DIR = 18;
  localparam int N_RND = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] y;
  logic        valid_out;

  fdiv_iter #(.ITER(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .y         (y),
    .valid_out (valid_out)
  );

  typedef struct {
    logic [31:0] y;
    logic        cmp;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] last_exp = 32'd0;

  // Directed vectors: dividend, divisor, hand-computed quotient.
  logic [31:0] dir_a [N_DIR] = '{
    32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000,
    32'h00800000, 32'h7F800000, 32'h3F800000, 32'h00000000, 32'h80000000,
    32'h3F800000, 32'h00000001, 32'h3F800000, 32'hC0C00000, 32'h40490FDB,
    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000};
  logic [31:0] dir_b [N_DIR] = '{
    32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h00800000,
    32'h7F000000, 32'h3F800000, 32'hFFC00000, 32'h7F800000, 32'h3F800000,
    32'h80000001, 32'h3F800000, 32'h3F7FFFFF, 32'h40000000, 32'h3F800000,
    32'h3F800000, 32'h3F000000, 32'h40000000};
  logic [31:0] dir_y [N_DIR] = '{
    32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h00000000, 32'h7F800000,
    32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
    32'hFF800000, 32'h00000000, 32'h3F800001, 32'hC0400000, 32'h40490FDB,
    32'h7F7FFFFF, 32'h7F800000, 32'h00000000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every valid_out must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      check("valid_out single pulse", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected valid_out: got y=%h want no response", y);
      end else begin
        cur = sb.pop_front();
        if (cur.cmp) begin
          check(cur.name, y, cur.y);
          last_exp = cur.y;
        end
        check({cur.name, " latency"}, 32'(cyc - cur.acc_cyc + 1), 32'(LAT));
      end
    end
    prev_valid = (valid_out === 1'b1);
  end

  // Issue one request when the DUT is ready; inputs are scrambled afterwards.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_y,
                      input logic cmp, input string name);
    int n = 0;
    @(negedge clk);
    while (ready_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_out !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s ready timeout: got ready_out=%b want 1", name, ready_out);
      return;
    end
    x1       = a;
    x2       = b;
    valid_in = 1'b1;
    sb.push_back('{exp_y, cmp, cyc + 1, name});
    @(negedge clk);
    valid_in = 1'b0;
    x1       = $urandom;
    x2       = $urandom;
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL response timeout: got %0d outstanding want 0", sb.size());
      sb.delete();
    end
  endtask

  // Reference: exact double quotient rounded to single (nearest even); this
  // equals the shortreal quotient. Subnormal-range results are not compared.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic cmp);
    real         ra, rb;
    logic [63:0] d;
    int          e;
    logic [22:0] frac;
    logic [28:0] rest;
    logic [23:0] fr;
    ra   = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
    rb   = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
    d    = $realtobits(ra / rb);
    e    = int'(d[62:52]) - 1023 + 127;
    frac = d[51:29];
    rest = d[28:0];
    r    = 32'd0;
    cmp  = 1'b1;
    if (e <= 0) begin
      cmp = 1'b0;
      return;
    end
    if (rest[28] && ((|rest[27:0]) || frac[0])) begin
      fr = {1'b0, frac} + 24'd1;
      if (fr[23]) e++;
      frac = fr[22:0];
    end
    if (e >= 255) r = {d[63], 8'hFF, 23'd0};
    else          r = {d[63], 8'(e), frac};
  endfunction

  logic [31:0] ra_op, rb_op, r_exp;
  logic        r_cmp;
  logic [7:0]  ea_r, eb_r;

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    x1       = 32'd0;
    x2       = 32'd0;
    repeat (3) @(negedge clk);
    check("reset ready_out", 32'(ready_out), 32'd1);
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset y", y, 32'd0);
    rst = 1'b0;

    // Directed vectors, back to back.
    for (int i = 0; i < N_DIR; i++) begin
      send(dir_a[i], dir_b[i], dir_y[i], 1'b1, $sformatf("dir%0d", i));
    end
    wait_empty(200);
    repeat (5) @(negedge clk);
    check("y held while idle", y, last_exp);

    // Abort 10 cycles into an operation; reset and a request collide.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b1, "aborted");
    repeat (8) @(negedge clk);
    check("ready_out low in DIV", 32'(ready_out), 32'd0);
    check("y held during op", y, last_exp);
    rst      = 1'b1;
    valid_in = 1'b1;
    x1       = 32'h40000000;
    x2       = 32'h3F800000;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check("ready after rst", 32'(ready_out), 32'd1);
    check("y cleared by rst", y, 32'd0);
    check("valid_out after rst", 32'(valid_out), 32'd0);
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    sb.push_back('{32'h3EAAAAAB, 1'b1, cyc + 1, "post-rst 1/3"});
    @(negedge clk);
    valid_in = 1'b0;
    // Requests during DIV must be ignored.
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(negedge clk);
      x1       = $urandom;
      x2       = $urandom;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
    end
    wait_empty(200);

    // Random normal operands against the reference.
    for (int i = 0; i < N_RND; i++) begin
      if (i % 8 == 0) begin
        ea_r = 8'($urandom_range(1, 254));
        eb_r = 8'($urandom_range(1, 254));
      end else begin
        ea_r = 8'($urandom_range(64, 190));
        eb_r = 8'($urandom_range(64, 190));
      end
      ra_op = {1'($urandom), ea_r, 23'($urandom)};
      rb_op = {1'($urandom), eb_r, 23'($urandom)};
      ref_div(ra_op, rb_op, r_exp, r_cmp);
      send(ra_op, rb_op, r_exp, r_cmp, $sformatf("rand%0d a=%h b=%h", i, ra_op, rb_op));
    end
    wait_empty(200);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdiv_iter.md
FDIV_ITER -- requirements
Module: fdiv_iter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-003 SHALL have port: x1  input  32  dividend, IEEE-754 single.
REQ-004 SHALL have port: x2  input  32  divisor, IEEE-754 single.
REQ-005 SHALL have port: valid_in  input  1  request; operands sampled when valid_in && ready_out.
REQ-006 SHALL have port: ready_out  output  1  high only while idle, able to accept.
REQ-007 SHALL have port: y  output  32  quotient x1/x2, IEEE-754 single.
REQ-008 SHALL have port: valid_out  output  1  one-cycle pulse; y valid in that cycle.
REQ-009 SHALL have parameter: ITER, default 26, number of quotient bits produced by the divide loop.

Function
REQ-010 SHALL use FSM states IDLE, DIV, NORM, DONE: IDLE->DIV on accept; DIV->NORM after ITER iterations; NORM->DONE; DONE->IDLE.
REQ-011 SHALL latch x1, x2 on the accepting edge; later input changes do not affect the result.
REQ-012 SHALL drive ready_out=1 in IDLE only; valid_in outside IDLE is ignored, not queued.
REQ-013 SHALL assert valid_out for exactly one cycle (DONE), ITER+2 = 28 edges after the accepting edge, for every operand class.
REQ-014 SHALL hold y stable from DONE until the next DONE.
REQ-015 SHALL produce one quotient bit per DIV cycle by restoring division of 24-bit significands (hidden 1 included): 1 integer bit + 25 fraction bits.
REQ-016 SHALL form a sticky bit from the OR of the final remainder.
REQ-017 SHALL compute the exponent as ea - eb + 127 in a 10-bit signed intermediate, minus 1 when the quotient integer bit is 0 (left-normalize 1 bit).
REQ-018 SHALL round to nearest, ties to even, using guard + sticky; a mantissa carry-out increments the exponent.
REQ-019 SHALL set sign = x1[31] XOR x2[31] for all results, including zero and infinity.
REQ-020 SHALL return ±inf (exp 255, mant 0) when the final exponent is >= 255.
REQ-021 SHALL return ±0 when the final exponent is <= 0; no denormal outputs.
REQ-022 SHALL treat inputs with exponent 0 as ±0 (denormal flush).
REQ-023 SHALL use special-case precedence: any input exponent 255 -> 0x7FC00000; else x1 zero -> ±0, including 0/0; else x2 zero -> ±inf.
REQ-024 SHALL still traverse DIV/NORM for special cases so latency is unchanged.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, enter IDLE with ready_out=1, valid_out=0, y=0x00000000, and clear iteration counter and datapath registers.
REQ-026 SHALL, on rst mid-operation, abort it: no valid_out for the aborted request, and accept again in the first cycle after rst deasserts.
REQ-027 SHALL give rst priority over valid_in in the same cycle.

Verification
REQ-028 SHALL verify 0x40C00000 / 0x40000000 (6/2) -> y=0x40400000, valid_out exactly 28 cycles after accept, single-cycle pulse.
REQ-029 SHALL verify 0x3F800000 / 0x40400000 (1/3) -> y=0x3EAAAAAB (rounded up).
REQ-030 SHALL verify 0xBF800000 / 0x00000000 -> 0xFF800000, and 0x00000000 / 0x00000000 -> 0x00000000, each at 28 cycles.
REQ-031 SHALL verify 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow), and 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
REQ-032 SHALL verify rst pulsed 10 cycles into an operation -> no valid_out; a request in the next cycle completes correctly; valid_in pulses during DIV are ignored.
REQ-033 SHALL run 1024 random normal-operand pairs against a shortreal reference, requiring bit-exact y wherever the reference result is normal or infinite.
